// File: rtl/reg_bank16_pkg.sv
// reg_bank16_pkg: shared constants and types for the 16 x 32-bit register bank.
//   XLEN     register width in bits
//   NREGS    number of registers (fixed to 16 to match the 16:1 read mux)
//   AW       register index width
//   ZERO_REG index of the hardwired-zero register
package reg_bank16_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 16;
    localparam int unsigned AW    = 4;

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] xword_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/reg_bank16_reg_scoreboard.sv
// reg_scoreboard: per-register pending scoreboard for long-latency producers.
// Optional feature macro: REGBANK_BYPASS_EN (a same-cycle writeback releases busy).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_wr_en, i_wr_addr         writeback strobe / destination (clears pending)
//   i_iss_en, i_iss_addr       long-latency issue strobe / destination (sets pending)
//   i_rs1_addr, i_rs2_addr     decode-stage source indices
//   o_pend                     pending bit per register
//   o_rs1_busy, o_rs2_busy     source not valid this cycle
//   o_stall                    rs1_busy | rs2_busy
//   o_iss_err                  one-cycle pulse after issue to an already-pending register
module reg_scoreboard
    import reg_bank16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  reg_idx_t         i_wr_addr,
    input  logic             i_iss_en,
    input  reg_idx_t         i_iss_addr,
    input  reg_idx_t         i_rs1_addr,
    input  reg_idx_t         i_rs2_addr,
    output logic [NREGS-1:0] o_pend,
    output logic             o_rs1_busy,
    output logic             o_rs2_busy,
    output logic             o_stall,
    output logic             o_iss_err
);

    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_d;
    logic             r_iss_err;
    logic             w_iss_err_d;
    logic             w_wr_valid;
    logic             w_iss_valid;

    assign w_wr_valid  = i_wr_en  && (i_wr_addr  != ZERO_REG);
    assign w_iss_valid = i_iss_en && (i_iss_addr != ZERO_REG);

    // Issue beats a same-index write: the issue names the newer producer.
    always_comb begin
        w_pend_d = r_pend;
        for (int n = 1; n < NREGS; n++) begin
            if (w_iss_valid && (i_iss_addr == reg_idx_t'(n))) begin
                w_pend_d[n] = 1'b1;
            end else if (w_wr_valid && (i_wr_addr == reg_idx_t'(n))) begin
                w_pend_d[n] = 1'b0;
            end
        end
        w_pend_d[0] = 1'b0;
    end

    // A same-index write retires the old producer, so re-issue is then legal.
    assign w_iss_err_d = w_iss_valid && r_pend[i_iss_addr] &&
                         !(w_wr_valid && (i_wr_addr == i_iss_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend    <= '0;
            r_iss_err <= 1'b0;
        end else begin
            r_pend    <= w_pend_d;
            r_iss_err <= w_iss_err_d;
        end
    end

    function automatic logic busy_of(input reg_idx_t rs, input logic [NREGS-1:0] pend,
                                     input logic wr_en, input reg_idx_t wr_addr);
        logic wr_hit;
        wr_hit = wr_en && (wr_addr == rs);
`ifdef REGBANK_BYPASS_EN
        return (rs != ZERO_REG) && pend[rs] && !wr_hit;
`else
        // Written value is not visible until the next cycle, so the write itself stalls.
        return (rs != ZERO_REG) && (pend[rs] || wr_hit);
`endif
    endfunction

    assign o_rs1_busy = busy_of(i_rs1_addr, r_pend, i_wr_en, i_wr_addr);
    assign o_rs2_busy = busy_of(i_rs2_addr, r_pend, i_wr_en, i_wr_addr);
    assign o_stall    = o_rs1_busy | o_rs2_busy;
    assign o_pend     = r_pend;
    assign o_iss_err  = r_iss_err;

endmodule

// File: rtl/reg_bank16.sv
// reg_bank16: 16 x 32-bit architectural register bank feeding a 16:1 read mux.
// Optional feature macro: REGBANK_BYPASS_EN (writeback data forwarded onto regs_flat).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_wr_en/i_wr_addr/i_wr_data   writeback
//   i_iss_en/i_iss_addr        long-latency producer issue (marks destination pending)
//   i_rs1_addr, i_rs2_addr     decode-stage sources
//   o_regs_flat                register n at bits [n*XLEN +: XLEN], slot n feeds mux input dn
//   o_pend                     pending bit per register
//   o_rs1_busy, o_rs2_busy     source not valid this cycle
//   o_stall                    rs1_busy | rs2_busy
//   o_iss_err                  one-cycle pulse on issue to an already-pending register
module reg_bank16
    import reg_bank16_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [XLEN-1:0]       i_wr_data,
    input  logic                  i_iss_en,
    input  logic [AW-1:0]         i_iss_addr,
    input  logic [AW-1:0]         i_rs1_addr,
    input  logic [AW-1:0]         i_rs2_addr,
    output logic [NREGS*XLEN-1:0] o_regs_flat,
    output logic [NREGS-1:0]      o_pend,
    output logic                  o_rs1_busy,
    output logic                  o_rs2_busy,
    output logic                  o_stall,
    output logic                  o_iss_err
);

    xword_t r_regs [NREGS];
    logic   w_wr_valid;

    assign w_wr_valid = i_wr_en && (i_wr_addr != ZERO_REG);

    // r_regs[0] is reset to zero and never written, so it reads as hardwired zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NREGS; n++) begin
                r_regs[n] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    always_comb begin
        o_regs_flat = '0;
        for (int n = 0; n < NREGS; n++) begin
            o_regs_flat[n*XLEN +: XLEN] = r_regs[n];
`ifdef REGBANK_BYPASS_EN
            if (w_wr_valid && (i_wr_addr == reg_idx_t'(n))) begin
                o_regs_flat[n*XLEN +: XLEN] = i_wr_data;
            end
`endif
        end
    end

    reg_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (i_wr_en),
        .i_wr_addr  (i_wr_addr),
        .i_iss_en   (i_iss_en),
        .i_iss_addr (i_iss_addr),
        .i_rs1_addr (i_rs1_addr),
        .i_rs2_addr (i_rs2_addr),
        .o_pend     (o_pend),
        .o_rs1_busy (o_rs1_busy),
        .o_rs2_busy (o_rs2_busy),
        .o_stall    (o_stall),
        .o_iss_err  (o_iss_err)
    );

endmodule

// File: tb/tb_reg_bank16.sv
// tb_reg_bank16: directed self-checking bench for reg_bank16.
// Expectations follow REGBANK_BYPASS_EN when the macro is defined for the build.
module tb_reg_bank16;

    logic         clk;
    logic         rst_n;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         iss_en;
    logic [3:0]   iss_addr;
    logic [3:0]   rs1_addr;
    logic [3:0]   rs2_addr;
    logic [511:0] regs_flat;
    logic [15:0]  pend;
    logic         rs1_busy;
    logic         rs2_busy;
    logic         stall;
    logic         iss_err;

    int checks;
    int errors;

    logic [511:0] exp_flat;

    reg_bank16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_iss_en    (iss_en),
        .i_iss_addr  (iss_addr),
        .i_rs1_addr  (rs1_addr),
        .i_rs2_addr  (rs2_addr),
        .o_regs_flat (regs_flat),
        .o_pend      (pend),
        .o_rs1_busy  (rs1_busy),
        .o_rs2_busy  (rs2_busy),
        .o_stall     (stall),
        .o_iss_err   (iss_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        exp_flat = '0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        rs1_addr = '0;
        rs2_addr = '0;
        #3;
        check("reset_flat", regs_flat, '0);
        check("reset_pend", 512'(pend), 512'(16'h0000));
        check("reset_stall", 512'(stall), 512'(1'b0));
        check("reset_iss_err", 512'(iss_err), 512'(1'b0));
        step();
        rst_n = 1'b1;
        step();

        // Write r5, visible one cycle later
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
        step();
        wr_en = 1'b0;
        exp_flat[5*32 +: 32] = 32'hDEADBEEF;
        check("wr_r5_flat", regs_flat, exp_flat);
        check("wr_r5_pend", 512'(pend), 512'(16'h0000));

        // Write r0 is ignored; rs1=0 never busy even with a write in flight
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h12345678; rs1_addr = 4'd0;
        #1;
        check("r0_rs1_busy", 512'(rs1_busy), 512'(1'b0));
        step();
        wr_en = 1'b0;
        check("r0_flat", regs_flat, exp_flat);

        // Issue r7 and hold rs1=7
        iss_en = 1'b1; iss_addr = 4'd7;
        step();
        iss_en = 1'b0; rs1_addr = 4'd7;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("r7_pend_stall", 512'(stall), 512'(1'b1));
            check("r7_pend", 512'(pend), 512'(16'h0080));
            step();
        end
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hA5A5A5A5;
        #1;
`ifdef REGBANK_BYPASS_EN
        check("r7_wr_cycle_stall", 512'(stall), 512'(1'b0));
        check("r7_bypass_slot", 512'(regs_flat[7*32 +: 32]), 512'(32'hA5A5A5A5));
`else
        check("r7_wr_cycle_stall", 512'(stall), 512'(1'b1));
        check("r7_no_bypass_slot", 512'(regs_flat[7*32 +: 32]), 512'(32'h0));
`endif
        step();
        wr_en = 1'b0;
        exp_flat[7*32 +: 32] = 32'hA5A5A5A5;
        #1;
        check("r7_after_stall", 512'(stall), 512'(1'b0));
        check("r7_after_pend", 512'(pend), 512'(16'h0000));
        check("r7_after_flat", regs_flat, exp_flat);
        rs1_addr = 4'd0;

        // Same-edge write and issue to r3: data lands, pend stays set, no error
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h1;
        iss_en = 1'b1; iss_addr = 4'd3;
        step();
        wr_en = 1'b0; iss_en = 1'b0;
        exp_flat[3*32 +: 32] = 32'h1;
        check("r3_flat", regs_flat, exp_flat);
        check("r3_pend", 512'(pend), 512'(16'h0008));
        check("r3_iss_err0", 512'(iss_err), 512'(1'b0));
        // Re-issue r3 while pending -> single-cycle error pulse
        iss_en = 1'b1; iss_addr = 4'd3;
        step();
        iss_en = 1'b0;
        check("r3_iss_err1", 512'(iss_err), 512'(1'b1));
        check("r3_pend_kept", 512'(pend), 512'(16'h0008));
        step();
        check("r3_iss_err_drop", 512'(iss_err), 512'(1'b0));
        check("r3_pend_still", 512'(pend), 512'(16'h0008));

        // Two pending sources, release one at a time
        iss_en = 1'b1; iss_addr = 4'd2;
        step();
        iss_addr = 4'd9;
        step();
        iss_en = 1'b0;
        rs1_addr = 4'd2; rs2_addr = 4'd9;
        #1;
        check("two_pend", 512'(pend), 512'(16'h020C));
        check("two_rs1_busy", 512'(rs1_busy), 512'(1'b1));
        check("two_rs2_busy", 512'(rs2_busy), 512'(1'b1));
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h22;
        #1;
`ifdef REGBANK_BYPASS_EN
        check("r2_wr_rs1_busy", 512'(rs1_busy), 512'(1'b0));
`else
        check("r2_wr_rs1_busy", 512'(rs1_busy), 512'(1'b1));
`endif
        check("r2_wr_stall", 512'(stall), 512'(1'b1));
        step();
        wr_en = 1'b0;
        #1;
        check("r2_done_rs1", 512'(rs1_busy), 512'(1'b0));
        check("r2_done_rs2", 512'(rs2_busy), 512'(1'b1));
        check("r2_done_stall", 512'(stall), 512'(1'b1));
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h99;
        step();
        wr_en = 1'b0;
        #1;
        exp_flat[2*32 +: 32] = 32'h22;
        exp_flat[9*32 +: 32] = 32'h99;
        check("r9_done_stall", 512'(stall), 512'(1'b0));
        check("r9_done_pend", 512'(pend), 512'(16'h0008));
        check("r9_done_flat", regs_flat, exp_flat);

        // Async reset mid-cycle clears everything before the next edge
        iss_en = 1'b1; iss_addr = 4'd2;
        step();
        iss_addr = 4'd9;
        step();
        iss_en = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h55;
        step();
        wr_en = 1'b0;
        #1;
        check("pre_rst_stall", 512'(stall), 512'(1'b1));
        check("pre_rst_r4", 512'(regs_flat[4*32 +: 32]), 512'(32'h55));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_flat", regs_flat, '0);
        check("async_rst_pend", 512'(pend), 512'(16'h0000));
        check("async_rst_stall", 512'(stall), 512'(1'b0));
        check("async_rst_iss_err", 512'(iss_err), 512'(1'b0));
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_flat", regs_flat, '0);
        check("post_rst_pend", 512'(pend), 512'(16'h0000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank16.md
Name: reg_bank16

Overview:
- 16 x 32-bit architectural register bank.
- Sits directly upstream of the 16:1 read-select mux: presents every register as a flattened bus whose slots feed the mux data inputs d0..d15.
- Owns writeback and a per-register pending scoreboard for long-latency producers (loads, multi-cycle ops).
- Generates the decode-stage stall when a source register is not yet valid.

Parameters:
- XLEN, 32, register width in bits.
- NREGS, 16, number of registers; fixed to 16 to match the 16:1 mux.
- AW, 4, register index width, log2(NREGS).

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- wr_en  input  1  writeback strobe
- wr_addr  input  AW  writeback destination
- wr_data  input  XLEN  writeback data
- iss_en  input  1  issue of a long-latency producer; marks destination pending
- iss_addr  input  AW  destination of issued producer
- rs1_addr  input  AW  decode-stage source 1 index
- rs2_addr  input  AW  decode-stage source 2 index
- regs_flat  output  NREGS*XLEN  register n at bits [n*XLEN+XLEN-1 : n*XLEN]; slot n drives mux input dn
- pend  output  NREGS  pending bit per register
- rs1_busy  output  1  source 1 not valid this cycle
- rs2_busy  output  1  source 2 not valid this cycle
- stall  output  1  rs1_busy | rs2_busy
- iss_err  output  1  registered one-cycle pulse on issue to an already-pending register

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on rst_n. Asserting rst_n low at any time, including mid-operation, immediately clears all registers to 0, pend to 0 and iss_err to 0. Any in-flight producer is forgotten.
- Register 0 is hardwired to zero:
  - writes to it are ignored;
  - issue to it is ignored;
  - pend[0] is always 0;
  - rs==0 is never busy.
- Write: on a rising edge with wr_en=1 and wr_addr!=0, the register takes wr_data and pend[wr_addr] clears.
  - The new value appears on regs_flat the next cycle (latency 1).
- Issue: on a rising edge with iss_en=1 and iss_addr!=0, pend[iss_addr] sets.
- Simultaneous write and issue to the same index: data is written and pend stays 1; the issue wins because it names the newer producer.
- Simultaneous write and issue to different indices: both take effect independently.
- iss_err: set for exactly one cycle after an edge where iss_en=1, iss_addr!=0, pend[iss_addr]=1 and no same-cycle write clears it. The bank takes no other action; pend stays 1.
- Busy, combinational from the current state and inputs:
  - rsX_busy = (rsX!=0) & (pend[rsX] | (wr_en & wr_addr==rsX)).
  - This variant is without the bypass feature: a same-cycle write is not yet visible, so the reader stalls one cycle.
- stall: combinational OR of rs1_busy and rs2_busy. No registered delay.
- regs_flat: driven directly from the register flops; no combinational path from inputs unless the bypass feature is enabled.

Optional Feature:
- Macro: REGBANK_BYPASS_EN.
- Defined:
  - regs_flat slot wr_addr shows wr_data combinationally in the cycle wr_en=1, for wr_addr!=0.
  - rsX_busy = (rsX!=0) & pend[rsX] & ~(wr_en & wr_addr==rsX), i.e. a writeback releases the stall in the same cycle.
- Undefined: behaviour exactly as in Behaviour, with one extra stall cycle per writeback-to-read hazard.

Decomposition:
- Shared package holds:
  - constants XLEN=32, NREGS=16, AW=4;
  - typedef reg_idx_t (AW bits);
  - typedef xword_t (XLEN bits);
  - localparam ZERO_REG=0.
- One natural sub-module: reg_scoreboard. It holds the pend vector, issue/clear/priority logic, iss_err generation and the busy/stall lookups. The top holds the data flops, flattening and optional bypass.

Test Plan:
- Reset, then write 0xDEADBEEF to r5 -> regs_flat[191:160]=0xDEADBEEF one cycle later; all other slots 0; pend=0.
- Write 0x12345678 to r0 -> slot 0 stays 0; rs1_addr=0 -> rs1_busy=0.
- Issue r7, then rs1_addr=7 for 3 cycles -> stall=1 each cycle; write r7=0xA5A5A5A5 -> no bypass: stall=1 in the write cycle, 0 the next; with REGBANK_BYPASS_EN: stall=0 in the write cycle and slot 7 shows 0xA5A5A5A5 combinationally.
- Same-edge write r3=0x1 and issue r3 -> r3=0x1, pend[3]=1, iss_err=0; then issue r3 again -> iss_err=1 for exactly one cycle, pend[3]=1.
- Issue r2 and r9, write r4=0x55, then drop rst_n asynchronously mid-cycle -> regs_flat=0, pend=0, stall=0 immediately, before the next clk edge.
- rs1_addr=2, rs2_addr=9 with both pending; write r2 only -> rs1_busy clears, rs2_busy=1, stall stays 1 until r9 is written.
